// File: rtl/micro_sequencer_pkg.sv
// Shared opcode set and instruction field layout for the micro sequencer.
// The opcode sits in the upper bits and the register number in the low REG_WIDTH bits.
package micro_sequencer_pkg;

  localparam int REG_WIDTH         = 4;
  localparam int OPCODE_WIDTH      = 4;
  localparam int INSTRUCTION_WIDTH = OPCODE_WIDTH + REG_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 4'h5;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_XOR  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LOAD,
    SEL_STORE,
    SEL_ALU
  } strobe_sel_t;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = {OP_NOP, {REG_WIDTH{1'b0}}};

  function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(
    input logic [OPCODE_WIDTH-1:0] op,
    input logic [REG_WIDTH-1:0]    r
  );
    return {op, r};
  endfunction

endpackage

// File: rtl/micro_sequencer_decode.sv
// Combinational opcode decoder: splits an instruction word into register field,
// ALU operation and which datapath strobe the instruction needs.
module instr_decode
  import micro_sequencer_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [REG_WIDTH-1:0]         reg_sel,
  output logic [1:0]                   alu_op,
  output strobe_sel_t                  strobe_sel,
  output logic                         illegal
);

  logic [OPCODE_WIDTH-1:0] opcode;

  assign opcode  = instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign reg_sel = instr[REG_WIDTH-1:0];

  // Non-ALU instructions report pass so alu_op never suggests a stray operation.
  always_comb begin
    alu_op     = ALU_PASS;
    strobe_sel = SEL_NONE;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_LD:  strobe_sel = SEL_LOAD;
      OP_ST:  strobe_sel = SEL_STORE;
      OP_ADD: begin strobe_sel = SEL_ALU; alu_op = ALU_ADD; end
      OP_SUB: begin strobe_sel = SEL_ALU; alu_op = ALU_SUB; end
      OP_XOR: begin strobe_sel = SEL_ALU; alu_op = ALU_XOR; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute sequencer walking ROM addresses FIRST_ADDR..LAST_ADDR once per start.
// Handshake: start is sampled only in IDLE; exec_wait holds EXECUTE; abort forces IDLE from any busy state.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned FIRST_ADDR = 1,
  parameter int unsigned LAST_ADDR  = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         exec_wait,
  output logic [4:0]                   rom_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
  output logic [REG_WIDTH-1:0]         reg_sel,
  output logic [1:0]                   alu_op,
  output logic                         acc_load,
  output logic                         reg_we,
  output logic                         alu_en,
  output logic                         busy,
  output logic                         done,
  output logic                         illegal,
  output logic [5:0]                   instr_count,
  output logic [2:0]                   fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [4:0] FIRST_PC  = 5'(FIRST_ADDR);
  localparam logic [4:0] LAST_PC   = 5'(LAST_ADDR);
  localparam bit         EMPTY_RUN = (FIRST_ADDR > LAST_ADDR);

  state_t                       state;
  logic [4:0]                   pc;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic                         acc_load_q;
  logic                         reg_we_q;
  logic                         alu_en_q;
  strobe_sel_t                  dec_sel;
  logic                         dec_illegal;

  instr_decode u_decode (
    .instr      (ir),
    .reg_sel    (reg_sel),
    .alu_op     (alu_op),
    .strobe_sel (dec_sel),
    .illegal    (dec_illegal)
  );

  // An abort landing in EXECUTE must not let the datapath commit in that cycle.
  assign acc_load  = acc_load_q & ~abort;
  assign reg_we    = reg_we_q   & ~abort;
  assign alu_en    = alu_en_q   & ~abort;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= FIRST_PC;
      rom_addr    <= 5'd0;
      ir          <= NOP_INSTR;
      acc_load_q  <= 1'b0;
      reg_we_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            pc          <= FIRST_PC;
            instr_count <= 6'd0;
            illegal     <= 1'b0;
            if (EMPTY_RUN) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              busy     <= 1'b1;
              rom_addr <= FIRST_PC;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ir    <= rom_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= S_EXECUTE;
            acc_load_q <= (dec_sel == SEL_LOAD);
            reg_we_q   <= (dec_sel == SEL_STORE);
            alu_en_q   <= (dec_sel == SEL_ALU);
          end
        end
        S_EXECUTE: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            acc_load_q <= 1'b0;
            reg_we_q   <= 1'b0;
            alu_en_q   <= 1'b0;
          end else if (!exec_wait) begin
            acc_load_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            alu_en_q    <= 1'b0;
            instr_count <= instr_count + 6'd1;
            if (dec_illegal) illegal <= 1'b1;
            if (pc == LAST_PC) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc       <= pc + 5'd1;
              rom_addr <= pc + 5'd1;
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a reference model turns the ROM image into the expected
// sequence of strobe events, and a monitor compares each retired strobe against it.
`timescale 1ns/1ps
module tb_micro_sequencer;
  import micro_sequencer_pkg::*;

  localparam int EVW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic exec_wait = 1'b0;

  logic [4:0]                   rom_addr, rom_addr_e;
  logic [INSTRUCTION_WIDTH-1:0] rom_data, rom_data_e;
  logic [REG_WIDTH-1:0]         reg_sel, reg_sel_e;
  logic [1:0]                   alu_op, alu_op_e;
  logic acc_load, reg_we, alu_en, busy, done, illegal;
  logic acc_load_e, reg_we_e, alu_en_e, busy_e, done_e, illegal_e;
  logic [5:0] instr_count, instr_count_e;
  logic [2:0] fsm_state, fsm_state_e;

  logic [INSTRUCTION_WIDTH-1:0] rom_mem [32];

  assign rom_data   = rom_mem[rom_addr];
  assign rom_data_e = rom_mem[rom_addr_e];

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exec_wait(exec_wait),
    .rom_addr(rom_addr), .rom_data(rom_data), .reg_sel(reg_sel), .alu_op(alu_op),
    .acc_load(acc_load), .reg_we(reg_we), .alu_en(alu_en), .busy(busy), .done(done),
    .illegal(illegal), .instr_count(instr_count), .fsm_state(fsm_state)
  );

  micro_sequencer #(.FIRST_ADDR(5), .LAST_ADDR(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exec_wait(exec_wait),
    .rom_addr(rom_addr_e), .rom_data(rom_data_e), .reg_sel(reg_sel_e), .alu_op(alu_op_e),
    .acc_load(acc_load_e), .reg_we(reg_we_e), .alu_en(alu_en_e), .busy(busy_e), .done(done_e),
    .illegal(illegal_e), .instr_count(instr_count_e), .fsm_state(fsm_state_e)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int busy_cycles = 0;
  int strobe_len = 0;
  logic [EVW-1:0] exp_q[$];
  int exp_len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event = {address, {alu_en, reg_we, acc_load}, register, alu op}; returns 0 for no strobe.
  function automatic bit model_event(input int addr, input logic [INSTRUCTION_WIDTH-1:0] w,
                                     output logic [EVW-1:0] ev, output bit bad);
    int op, r;
    logic [2:0] strb;
    logic [1:0] aop;
    op   = int'(w) >> REG_WIDTH;
    r    = int'(w) & ((1 << REG_WIDTH) - 1);
    bad  = 1'b0;
    strb = 3'b000;
    aop  = 2'd3;
    case (op)
      0: ;
      1: strb = 3'b001;
      2: strb = 3'b010;
      3: begin strb = 3'b100; aop = 2'd0; end
      4: begin strb = 3'b100; aop = 2'd1; end
      5: begin strb = 3'b100; aop = 2'd2; end
      default: bad = 1'b1;
    endcase
    ev = {5'(addr), strb, 4'(r), aop};
    return strb != 3'b000;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_len = 0;
    end else begin
      if (busy) busy_cycles++;
      if (acc_load | reg_we | alu_en) begin
        strobe_len++;
        if (!exec_wait) begin
          logic [EVW-1:0] got, exp;
          int len;
          got = {rom_addr, alu_en, reg_we, acc_load, reg_sel, alu_op};
          if (exp_q.size() == 0) begin
            tests++;
            failures++;
            $display("FAIL unexpected_strobe: got 0x%0h expected no strobe", got);
          end else begin
            exp = exp_q.pop_front();
            len = exp_len_q.pop_front();
            check("strobe_event", 32'(got), 32'(exp));
            if (len > 0) check("strobe_len", strobe_len, len);
          end
          strobe_len = 0;
        end
      end else begin
        strobe_len = 0;
      end
    end
  end

  task automatic load_directed(input bit with_illegal);
    for (int a = 0; a < 32; a++) rom_mem[a] = NOP_INSTR;
    rom_mem[1] = make_instr(OP_LD, 4'd3);
    rom_mem[2] = make_instr(OP_ST, 4'd2);
    rom_mem[3] = make_instr(OP_ADD, 4'd2);
    rom_mem[4] = make_instr(OP_SUB, 4'd3);
    rom_mem[6] = make_instr(OP_XOR, 4'd3);
    rom_mem[7] = make_instr(OP_SUB, 4'd2);
    if (with_illegal) rom_mem[5] = make_instr(4'h7, 4'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_reg_sel"}, reg_sel, 0);
    check({tag, "_alu_op"}, alu_op, 3);
    check({tag, "_strobes"}, {alu_en, reg_we, acc_load}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_instr_count"}, instr_count, 0);
  endtask

  task automatic run_prog(input int stall_n, input int abort_at, input bit rand_wait,
                          input bit hold_start, input int exp_cycles);
    logic [EVW-1:0] ev;
    bit bad, exp_ill;
    int last;
    exp_ill = 1'b0;
    last = (abort_at != 0) ? abort_at - 1 : 31;
    for (int a = 1; a <= last; a++) begin
      if (model_event(a, rom_mem[a], ev, bad)) begin
        exp_q.push_back(ev);
        exp_len_q.push_back((a == 1 && stall_n > 0) ? stall_n + 1 : (rand_wait ? 0 : 1));
      end
      if (bad) exp_ill = 1'b1;
    end
    @(posedge clk); #1 start = 1'b1; busy_cycles = 0;
    @(posedge clk); #1 if (!hold_start) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("count_cleared", instr_count, 0);
    check("illegal_cleared", illegal, 0);
    check("first_fetch_addr", rom_addr, 1);
    check("empty_run_done", done_e, 1);
    check("empty_run_busy", busy_e, 0);
    check("empty_run_count", instr_count_e, 0);
    if (stall_n > 0) begin
      repeat (2) @(posedge clk);
      #1 exec_wait = 1'b1;
      repeat (stall_n) @(posedge clk);
      #1 exec_wait = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (3 * (abort_at - 1) + 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_count", instr_count, abort_at - 1);
    end else begin
      int cyc = 0;
      while (!done && cyc < 3000) begin
        @(posedge clk); #1;
        if (rand_wait) exec_wait = ($urandom_range(0, 2) == 0);
        cyc++;
      end
      exec_wait = 1'b0;
      check("done_reached", done, 1);
      check("busy_in_done", busy, 0);
      check("instr_count", instr_count, last);
      if (exp_cycles > 0) check("run_cycles", busy_cycles, exp_cycles);
      if (hold_start) begin
        repeat (4) begin
          @(posedge clk); #1;
          check("hold_done", done, 1);
          check("hold_no_restart", busy, 0);
        end
        start = 1'b0;
      end
      @(posedge clk); #1;
      check("done_to_idle", done, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("stay_idle", busy, 0);
    check("illegal_flag", illegal, exp_ill);
    check("events_left", exp_q.size(), 0);
    exp_q.delete();
    exp_len_q.delete();
  endtask

  initial begin
    load_directed(1'b0);
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_prog(0, 0, 1'b0, 1'b0, 93);
    run_prog(4, 0, 1'b0, 1'b0, 97);
    load_directed(1'b1);
    run_prog(0, 0, 1'b0, 1'b0, 93);
    load_directed(1'b0);
    run_prog(0, 3, 1'b0, 1'b0, 0);
    run_prog(0, 0, 1'b0, 1'b1, 93);

    // Reset pulse while the LD at address 1 is stalled in EXECUTE.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 exec_wait = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("stalled_strobe", acc_load, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    exec_wait = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_reset_idle", busy, 0);
      check("post_reset_strobes", {alu_en, reg_we, acc_load}, 0);
    end

    for (int run = 0; run < 3; run++) begin
      rom_mem[0] = NOP_INSTR;
      for (int a = 1; a < 32; a++)
        rom_mem[a] = make_instr(4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      run_prog(0, 0, 1'b1, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter FIRST_ADDR, default 1: first ROM address executed after start; address 0 is a reserved record and is never executed.
REQ-002 Parameter LAST_ADDR, default 31: final ROM address executed before completion.
REQ-003 Clock and reset are fixed:
- clk, input, 1 bit: single clock; all state changes on its rising edge.
- rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Control handshake:
- start, input, 1 bit: begin a program run (sampled only in IDLE).
- abort, input, 1 bit: cancel the run (synchronous).
- exec_wait, input, 1 bit: datapath stall; holds EXECUTE.
REQ-005 Instruction interface:
- rom_addr, output, 5 bits: instruction address to the ROM.
- rom_data, input, INSTRUCTION_WIDTH bits: instruction word from the combinational ROM.
REQ-006 Decoded instruction:
- reg_sel, output, REG_WIDTH bits: register field of the current instruction.
- alu_op, output, 2 bits: 0=ADD, 1=SUB, 2=XOR, 3=pass.
REQ-007 Datapath strobes:
- acc_load, output, 1 bit: LD strobe, ACC <= R[reg_sel].
- reg_we, output, 1 bit: ST strobe, R[reg_sel] <= ACC.
- alu_en, output, 1 bit: ALU strobe, ACC <= ACC alu_op R[reg_sel].
REQ-008 Status:
- busy, output, 1 bit: high in any state except IDLE and DONE.
- done, output, 1 bit: high in DONE.
- illegal, output, 1 bit: sticky flag for an unknown opcode.
- instr_count, output, 6 bits: number of instructions retired this run.

Function
REQ-009 The FSM SHALL have the states IDLE, FETCH, DECODE, EXECUTE and DONE.
REQ-010 IDLE SHALL go to FETCH when start=1, loading pc=FIRST_ADDR, clearing instr_count and clearing illegal.
REQ-011 FETCH SHALL drive rom_addr=pc, capture rom_data into the instruction register at the clock edge, and go to DECODE.
REQ-012 DECODE SHALL drive reg_sel and alu_op from the instruction register and go to EXECUTE.
REQ-013 EXECUTE SHALL assert exactly one strobe matching the opcode (LD->acc_load, ST->reg_we, ADD/SUB/XOR->alu_en), or no strobe for NOP.
REQ-014 While exec_wait=1, EXECUTE SHALL hold all outputs steady with the strobe kept asserted; it retires in the first cycle with exec_wait=0.
REQ-015 On retire, instr_count SHALL increment; if pc==LAST_ADDR the FSM goes to DONE, otherwise pc increments and the FSM goes to FETCH.
REQ-016 pc SHALL never wrap past LAST_ADDR.
REQ-017 An unstalled instruction SHALL take exactly 3 cycles.
REQ-018 An opcode not defined in the shared opcode set SHALL execute as NOP and set illegal, which stays set until the next start or reset.
REQ-019 DONE SHALL go to IDLE when start=0, and SHALL ignore start until it has returned to IDLE.
REQ-020 abort=1 in any busy state SHALL force IDLE on the next edge, suppress strobes in that cycle, and leave instr_count and illegal unchanged.
REQ-021 If abort and exec_wait are high together, abort SHALL win.
REQ-022 If abort and start are high together in IDLE, the FSM SHALL stay in IDLE.
REQ-023 Strobes SHALL be registered-state decodes, glitch-free, and low outside EXECUTE.
REQ-024 rom_addr SHALL hold its last value outside FETCH.
REQ-025 With FIRST_ADDR > LAST_ADDR, a start SHALL go directly to DONE with instr_count=0.

Reset
REQ-026 rst_n low SHALL asynchronously set: state=IDLE, pc=FIRST_ADDR, rom_addr=0, instruction register=NOP, reg_sel=0, alu_op=3, all strobes=0, busy=0, done=0, illegal=0, instr_count=0.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction without any strobe; after release the block waits for a new start.

Structure
REQ-028 Opcode codes, REG_WIDTH, OPCODE_WIDTH, INSTRUCTION_WIDTH and the field positions (opcode in the upper bits, register in the low REG_WIDTH bits) SHALL come from the shared opcode package; the FSM state encoding SHALL be local.
REQ-029 The combinational opcode decoder SHALL be the sub-module instr_decode (instruction in; reg_sel, alu_op, strobe-select, illegal out); no other sub-modules.

Verification
REQ-030 Reset then start, with the ROM holding 1:LD R3, 2:ST R2, 3:ADD R2, 4:SUB R3, 6:XOR R3, 7:SUB R2 and NOP elsewhere -> strobes in this order: acc_load(reg_sel=3), reg_we(2), alu_en op0(2), alu_en op1(3), none, alu_en op2(3), alu_en op1(2); done after 93 cycles; instr_count=31.
REQ-031 exec_wait held high for 4 cycles in the EXECUTE of address 1 -> acc_load high for 5 cycles, pc stays 1, and the total run takes 97 cycles.
REQ-032 Opcode 0x7 (undefined) at address 5 -> no strobe at address 5, illegal=1 until the next start, and the run completes normally.
REQ-033 abort during the DECODE of address 3 -> IDLE on the next edge, no alu_en, instr_count=2; a following start restarts at address 1.
REQ-034 rst_n pulsed low during a stalled EXECUTE -> all outputs at reset values immediately, with no clock required; start=1 held through DONE -> no restart until start drops.
